dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder serving load/store requests from the pipeline's memory stage over a valid/ready request channel and a one-cycle response pulse.
- Owns the word-organised data RAM and performs byte, halfword and word accesses, with sign or zero extension on loads.
- Inserts a programmable number of wait states to model slow memory.
- Detects misaligned and out-of-range accesses and reports them as errors.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the RAM; valid word index is addr[31:2] < DEPTH_WORDS.
- LATENCY, 2, wait-state cycles between request acceptance and response; legal range 0..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_rdata  output  32  load result; 0 for stores and for errors.
- rsp_err  output  1  qualified by rsp_valid: misaligned, out-of-range or illegal size.
- busy  output  1  request in flight (state is not IDLE).

Behaviour:
- Reset: rst is sampled only at the clk edge. On reset the state is IDLE; rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0 and the wait counter is 0.
- req_ready is 0 while rst is high and 1 in IDLE otherwise.
- RAM contents are not reset. The simulation model initialises the RAM to 0.
- States:
  - IDLE: req_ready=1.
  - WAIT: a counter decrements each cycle.
  - RESP: rsp_valid=1 for exactly one cycle.
- Accept: at the edge where req_valid && req_ready, capture we, size, unsigned, addr and wdata.
  - LATENCY=0: go to RESP.
  - Otherwise: go to WAIT with counter=LATENCY.
- WAIT: at each edge the counter decrements. At the edge where counter==1, go to RESP.
- Timing: for a request accepted at edge k, the access executes at edge k+LATENCY, and rsp_valid is high in the following cycle. RESP returns to IDLE at the next edge.
- Throughput: one request per LATENCY+2 cycles. req_ready=0 in WAIT and RESP.
- There is no response backpressure. The requester stalls until it sees rsp_valid.
- Error check is made on the captured request:
  - size==11
  - half with addr[0]=1
  - word with addr[1:0]!=0
  - addr[31:2] >= DEPTH_WORDS
  - On error: no RAM write, rsp_err=1, rsp_rdata=0.
- Store, executed at the edge entering RESP:
  - Byte writes wdata[7:0] into lane addr[1:0].
  - Half writes wdata[15:0] into lane addr[1].
  - Word writes all 32 bits.
  - Other lanes are unchanged.
  - Response: rsp_rdata=0, rsp_err=0.
- Load, registered at the edge entering RESP:
  - Select the addressed byte or half and extend it per req_unsigned. Word loads ignore req_unsigned.
- Outside RESP: rsp_valid=0. rsp_rdata and rsp_err return to 0.
- Reset mid-operation: rst in WAIT discards the pending request with no RAM write and no response. rst in RESP cancels the pulse. The next state is IDLE.
- Back-to-back: a request held valid during WAIT/RESP is accepted at the first IDLE edge, with no lost or duplicated request.
- A load following a store to the same address returns the newly stored data.
- req_* inputs are ignored when not accepted.

Test Plan:
1. LATENCY=2. Store word 0xDEADBEEF to addr 0x10, accepted at edge k -> rsp_valid only in the cycle after edge k+2, rsp_err=0. A following word load from 0x10 returns 0xDEADBEEF.
2. Word 0x00000000 at 0x20. Store byte 0x80 to 0x22 -> signed byte load of 0x22 = 0xFFFFFF80, unsigned byte load = 0x00000080, word load = 0x00800000.
3. Half store 0x8001 to 0x32 then half loads of 0x32 -> signed 0xFFFF8001, unsigned 0x00008001. Lower half of word 0x30 is unchanged.
4. Errors, each with rsp_err=1, rsp_rdata=0 and no RAM change:
   - word load at 0x13 (misaligned)
   - half store at 0x15 (misaligned)
   - size=11 (illegal)
   - word access at 4*DEPTH_WORDS (0x1000 for the default DEPTH_WORDS, out of range)
5. LATENCY=0, req_valid held high for 3 requests -> acceptances 2 cycles apart, three single-cycle rsp_valid pulses, req_ready low in each RESP cycle.
6. Store of 0x12345678 to 0x40 accepted, rst pulsed during WAIT -> no rsp_valid. A subsequent word load of 0x40 returns its prior value (0). req_ready=1 one cycle after rst deasserts.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready load/store requests, programmable wait states,
// byte/half/word access with sign/zero extension, misalignment and range checking.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;

  logic          r_we, r_uns;
  logic [1:0]    r_size;
  logic [31:0]   r_addr, r_wdata;
  logic [31:0]   r_rdata;
  logic          r_err;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic          w_accept, w_go, w_bypass;
  logic          w_we, w_uns, w_err;
  logic [1:0]    w_size;
  logic [31:0]   w_addr, w_wdata;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_rword, w_wword, w_load;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;

  assign req_ready = (r_state == S_IDLE) && !rst;
  assign w_accept  = req_valid && req_ready;
  assign rsp_valid = (r_state == S_RESP);
  assign busy      = (r_state != S_IDLE);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

  // With zero latency the access happens on the accepting edge, so use the live request.
  assign w_go     = (LATENCY == 0) ? w_accept
                                   : ((r_state == S_WAIT) && (r_cnt == CW'(1)) && !rst);
  assign w_bypass = (r_state == S_IDLE);
  assign w_we     = w_bypass ? req_we       : r_we;
  assign w_uns    = w_bypass ? req_unsigned : r_uns;
  assign w_size   = w_bypass ? req_size     : r_size;
  assign w_addr   = w_bypass ? req_addr     : r_addr;
  assign w_wdata  = w_bypass ? req_wdata    : r_wdata;

  assign w_err = (w_size == 2'b11)
              || ((w_size == 2'b01) && w_addr[0])
              || ((w_size == 2'b10) && (w_addr[1:0] != 2'b00))
              || ({2'b00, w_addr[31:2]} >= 32'(DEPTH_WORDS));

  assign w_idx   = w_addr[AW+1:2];
  assign w_rword = r_mem[w_idx];
  assign w_byte  = w_rword[{w_addr[1:0], 3'b000} +: 8];
  assign w_half  = w_rword[{w_addr[1], 4'b0000} +: 16];

  // Lane extraction and extension for loads
  always_comb begin
    w_load = w_rword;
    case (w_size)
      2'b00:   w_load = w_uns ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_load = w_uns ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load = w_rword;
    endcase
  end

  // Read-modify-write merge for stores
  always_comb begin
    w_wword = w_rword;
    case (w_size)
      2'b00:   w_wword[{w_addr[1:0], 3'b000} +: 8] = w_wdata[7:0];
      2'b01:   w_wword[{w_addr[1], 4'b0000} +: 16] = w_wdata[15:0];
      default: w_wword = w_wdata;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (LATENCY == 0) begin
            w_state_nxt = S_RESP;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = CW'(LATENCY);
          end
        end
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) w_state_nxt = S_RESP;
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_go) begin
        r_rdata <= (w_we || w_err) ? 32'h0 : w_load;
        r_err   <= w_err;
      end else begin
        r_rdata <= '0;
        r_err   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we    <= req_we;
      r_uns   <= req_unsigned;
      r_size  <= req_size;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
    end
  end

  // RAM is not reset; erroneous or reset-cancelled stores never write
  always_ff @(posedge clk) begin
    if (w_go && w_we && !w_err) r_mem[w_idx] <= w_wword;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus random traffic
// checked against a byte-addressed reference memory.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned WIN   = 128;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic        rsp_valid, rsp_err, busy;

  logic        rst0, req_valid0, req_ready0, req_we0, req_unsigned0;
  logic [1:0]  req_size0;
  logic [31:0] req_addr0, req_wdata0, rsp_rdata0;
  logic        rsp_valid0, rsp_err0, busy0;

  int n_chk  = 0;
  int n_pass = 0;
  logic [7:0] mem_m [WIN];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst0), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_we(req_we0), .req_size(req_size0), .req_unsigned(req_unsigned0),
    .req_addr(req_addr0), .req_wdata(req_wdata0), .rsp_valid(rsp_valid0),
    .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0), .busy(busy0)
  );

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  function automatic logic model_err(input logic [1:0] sz, input logic [31:0] a);
    int unsigned nb;
    nb = 32'd1 << sz;
    return (sz == 2'd3) || ((a % nb) != 0) || ((a / 4) >= DEPTH);
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns,
                                             input logic [31:0] a);
    logic [31:0] v;
    int unsigned nb;
    nb = 32'd1 << sz;
    v  = '0;
    for (int i = 0; i < int'(nb); i++) v = v | (32'(mem_m[a + 32'(i)]) << (8 * i));
    if (!uns && nb < 4 && v[8 * nb - 1]) v = v | ~((32'h1 << (8 * nb)) - 32'h1);
    return v;
  endfunction

  // One transaction on the LATENCY=2 instance; entered and left just after a falling edge.
  task automatic txn(input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] a, input logic [31:0] wd, output logic [31:0] got);
    logic        e_err;
    logic [31:0] e_data;
    int          n;
    e_err  = model_err(sz, a);
    e_data = (we || e_err) ? 32'h0 : model_load(sz, uns, a);
    if (we && !e_err)
      for (int i = 0; i < (1 << sz); i++) mem_m[a + 32'(i)] = 8'(wd >> (8 * i));
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    chk1("busy_wait", busy, 1'b1);
    chk1("ready_wait", req_ready, 1'b0);
    n = 1;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk32("latency", 32'(n), 32'd3);
    chk1("rsp_err", rsp_err, e_err);
    chk32("rsp_rdata", rsp_rdata, e_data);
    got = rsp_rdata;
    @(negedge clk);
    chk1("pulse_end", rsp_valid, 1'b0);
    chk32("rdata_clear", rsp_rdata, 32'h0);
  endtask

  initial begin
    logic [31:0] got, a;
    logic [1:0]  sz;
    for (int i = 0; i < int'(WIN); i++) mem_m[i] = 8'h0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    rst0 = 1'b1; req_valid0 = 1'b0; req_we0 = 1'b0; req_size0 = 2'b10; req_unsigned0 = 1'b0;
    req_addr0 = '0; req_wdata0 = '0;
    repeat (3) @(negedge clk);
    chk1("rst_valid", rsp_valid, 1'b0);
    chk32("rst_rdata", rsp_rdata, 32'h0);
    chk1("rst_err", rsp_err, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_ready", req_ready, 1'b0);
    chk1("rst_ready0", req_ready0, 1'b0);
    rst = 1'b0; rst0 = 1'b0;
    #1;
    chk1("ready_after_rst", req_ready, 1'b1);

    // Establish a known-zero window in the RAM
    for (int w = 0; w < int'(WIN / 4); w++) txn(1'b1, 2'b10, 1'b0, 32'(4 * w), 32'h0, got);

    txn(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, got);
    txn(1'b0, 2'b10, 1'b0, 32'h10, $urandom, got);
    chk32("t1_word", got, 32'hDEADBEEF);

    txn(1'b1, 2'b00, 1'b0, 32'h22, 32'hABCDEF80, got);
    txn(1'b0, 2'b00, 1'b0, 32'h22, 32'h0, got);
    chk32("t2_sbyte", got, 32'hFFFFFF80);
    txn(1'b0, 2'b00, 1'b1, 32'h22, 32'h0, got);
    chk32("t2_ubyte", got, 32'h00000080);
    txn(1'b0, 2'b10, 1'b1, 32'h20, 32'h0, got);
    chk32("t2_word", got, 32'h00800000);

    txn(1'b1, 2'b10, 1'b0, 32'h30, 32'h0000CAFE, got);
    txn(1'b1, 2'b01, 1'b0, 32'h32, 32'h55558001, got);
    txn(1'b0, 2'b01, 1'b0, 32'h32, 32'h0, got);
    chk32("t3_shalf", got, 32'hFFFF8001);
    txn(1'b0, 2'b01, 1'b1, 32'h32, 32'h0, got);
    chk32("t3_uhalf", got, 32'h00008001);
    txn(1'b0, 2'b01, 1'b1, 32'h30, 32'h0, got);
    chk32("t3_lowhalf", got, 32'h0000CAFE);

    txn(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, got);
    txn(1'b1, 2'b01, 1'b0, 32'h15, 32'h0000FFFF, got);
    txn(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, got);
    txn(1'b1, 2'b10, 1'b0, 32'h1000, 32'hFFFFFFFF, got);
    txn(1'b1, 2'b10, 1'b0, 32'hFFFFFFFC, 32'hFFFFFFFF, got);
    txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, got);
    chk32("t4_keep10", got, 32'hDEADBEEF);
    txn(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, got);
    chk32("t4_keep14", got, 32'h0);
    txn(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, got);
    chk32("t4_keep00", got, 32'h0);

    // Zero-latency instance: requests held valid back to back
    req_valid0 = 1'b1; req_we0 = 1'b1; req_size0 = 2'b10; req_addr0 = 32'h0; req_wdata0 = 32'h11;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk1("l0_valid", rsp_valid0, (i % 2) == 0);
      chk1("l0_ready", req_ready0, (i % 2) != 0);
      chk1("l0_err", rsp_err0, 1'b0);
      if (i == 1) begin req_addr0 = 32'h4; req_wdata0 = 32'h22; end
      if (i == 3) begin req_addr0 = 32'h8; req_wdata0 = 32'h33; end
      if (i == 4) req_valid0 = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      req_valid0 = 1'b1; req_we0 = 1'b0; req_addr0 = 32'(4 * i);
      @(negedge clk);
      req_valid0 = 1'b0;
      chk1("l0_ld_valid", rsp_valid0, 1'b1);
      chk32("l0_ld_data", rsp_rdata0, 32'h11 * 32'(i + 1));
      @(negedge clk);
      chk1("l0_ld_end", rsp_valid0, 1'b0);
    end

    // Reset while a store waits: the store must vanish
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h40; req_wdata = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    chk1("t6_busy", busy, 1'b1);
    req_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk1("t6_valid_rst", rsp_valid, 1'b0);
    chk1("t6_busy_rst", busy, 1'b0);
    chk1("t6_ready_rst", req_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk1("t6_ready", req_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk1("t6_no_rsp", rsp_valid, 1'b0);
    end
    txn(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, got);
    chk32("t6_word40", got, 32'h0);

    // Random traffic against the reference memory
    for (int t = 0; t < 60; t++) begin
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = 32'h1000 + 32'($urandom_range(0, 4095)) * 4;
      else a = 32'($urandom_range(0, WIN - 1));
      if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((32'h1 << sz) - 32'h1);
      txn(1'($urandom), sz, 1'($urandom), a, $urandom, got);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
